// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode constants and the bit-vote helper.
// Kept separate so a future parametrised transmitter can reuse the same encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityOdd  = 1;
    localparam int unsigned ParityEven = 2;

    function automatic logic majority3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle: serial line and byte handshake between a UART receiver and its consumer.
interface uart_rx_param_if;

    logic       rx_serial;
    logic       rx_ready;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       brk;

    modport master (
        output rx_serial, rx_ready,
        input  rx_dv, rx_byte, parity_err, frame_err, overrun, brk
    );

    modport slave (
        input  rx_serial, rx_ready,
        output rx_dv, rx_byte, parity_err, frame_err, overrun, brk
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser (preset high) plus a 3-sample majority vote over the
// current and two previous synchronised samples.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic serial,
    output logic line,
    output logic vote
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial};
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign line = sync_q[1];
    // Read on the last count of a bit: samples at counts -1, -2 and -3.
    assign vote = majority3(line, hist_q[0], hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-bit qualification, voted data/parity/stop bits,
// break detection, and a valid/ready output holding register with overrun reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Parity_Err,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Break
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntMid   = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]      DataLast = 3'(DATA_BITS - 1);
    localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

    logic line;
    logic vote;

    uart_rx_sampler u_sampler (
        .clk    (i_Clock),
        .rst    (i_Reset),
        .serial (i_RX_Serial),
        .line   (line),
        .vote   (vote)
    );

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic            par_bit_q, par_bit_d;
    logic            frm_err_q, frm_err_d;
    logic            dv_q, dv_d;
    logic [7:0]      byte_q, byte_d;
    logic            pe_q, pe_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            brk_q, brk_d;
    logic            handshake;
    logic            bit_end;
    logic            complete;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            par_bit_q <= 1'b0;
            frm_err_q <= 1'b0;
            dv_q      <= 1'b0;
            byte_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            par_bit_q <= par_bit_d;
            frm_err_q <= frm_err_d;
            dv_q      <= dv_d;
            byte_q    <= byte_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            brk_q     <= brk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        par_bit_d = par_bit_q;
        frm_err_d = frm_err_q;
        dv_d      = dv_q;
        byte_d    = byte_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ovr_d     = 1'b0;
        brk_d     = 1'b0;
        complete  = 1'b0;
        handshake = dv_q & i_RX_Ready;
        bit_end   = (cnt_q == CntLast);

        if (handshake) dv_d = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!line) begin
                    state_d   = StStart;
                    shift_d   = '0;
                    par_err_d = 1'b0;
                    par_bit_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == CntMid) begin
                    cnt_d   = '0;
                    state_d = line ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = vote;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != ParityNone) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    par_bit_d = vote;
                    // Odd mode flags an even total, even mode flags an odd total.
                    par_err_d = ((^shift_q) ^ vote) == (PARITY_MODE == ParityEven);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd0 && !vote && shift_q == 8'h00 && !par_bit_q) begin
                        brk_d   = 1'b1;
                        state_d = StWaitIdle;
                    end else begin
                        if (!vote) frm_err_d = 1'b1;
                        if (bit_q == StopLast) begin
                            complete = 1'b1;
                            bit_d    = '0;
                            state_d  = frm_err_d ? StWaitIdle : StIdle;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (line) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A held, unaccepted byte wins over a newly completed frame.
        if (complete) begin
            if (dv_q && !handshake) begin
                ovr_d = 1'b1;
            end else begin
                dv_d   = 1'b1;
                byte_d = shift_q;
                pe_d   = par_err_q;
                fe_d   = frm_err_d;
            end
        end
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = pe_q;
    assign o_Frame_Err  = fe_q;
    assign o_Overrun    = ovr_q;
    assign o_Break      = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 7E1, 8N2) at 16 clocks per bit,
// expected frames queued at stimulus time and popped by a monitor on each valid/ready handshake.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned Cpb = 16;

    typedef struct packed {
        logic [7:0] b;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ser;
    logic [2:0] rdy;

    always #5 clk = ~clk;

    uart_rx_param_if u0 ();
    uart_rx_param_if u1 ();
    uart_rx_param_if u2 ();

    assign u0.rx_serial = ser[0];
    assign u1.rx_serial = ser[1];
    assign u2.rx_serial = ser[2];
    assign u0.rx_ready  = rdy[0];
    assign u1.rx_ready  = rdy[1];
    assign u2.rx_ready  = rdy[2];

    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_MODE(ParityNone), .STOP_BITS(1))
    dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(u0.rx_serial), .i_RX_Ready(u0.rx_ready),
        .o_RX_DV(u0.rx_dv), .o_RX_Byte(u0.rx_byte), .o_Parity_Err(u0.parity_err),
        .o_Frame_Err(u0.frame_err), .o_Overrun(u0.overrun), .o_Break(u0.brk)
    );

    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY_MODE(ParityEven), .STOP_BITS(1))
    dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(u1.rx_serial), .i_RX_Ready(u1.rx_ready),
        .o_RX_DV(u1.rx_dv), .o_RX_Byte(u1.rx_byte), .o_Parity_Err(u1.parity_err),
        .o_Frame_Err(u1.frame_err), .o_Overrun(u1.overrun), .o_Break(u1.brk)
    );

    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_MODE(ParityNone), .STOP_BITS(2))
    dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(u2.rx_serial), .i_RX_Ready(u2.rx_ready),
        .o_RX_DV(u2.rx_dv), .o_RX_Byte(u2.rx_byte), .o_Parity_Err(u2.parity_err),
        .o_Frame_Err(u2.frame_err), .o_Overrun(u2.overrun), .o_Break(u2.brk)
    );

    logic [2:0] dv_w, pe_w, fe_w, ov_w, bk_w;
    logic [7:0] by_w [3];

    assign dv_w = {u2.rx_dv, u1.rx_dv, u0.rx_dv};
    assign pe_w = {u2.parity_err, u1.parity_err, u0.parity_err};
    assign fe_w = {u2.frame_err, u1.frame_err, u0.frame_err};
    assign ov_w = {u2.overrun, u1.overrun, u0.overrun};
    assign bk_w = {u2.brk, u1.brk, u0.brk};
    assign by_w[0] = u0.rx_byte;
    assign by_w[1] = u1.rx_byte;
    assign by_w[2] = u2.rx_byte;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   brk_cnt [3] = '{0, 0, 0};
    int   ovr_cnt [3] = '{0, 0, 0};
    exp_t mon_e;
    bit   mon_ok;

    function automatic void chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", idx, name, got, exp);
        end
    endfunction

    function automatic exp_t mk(logic [7:0] b, logic pe, logic fe);
        exp_t e;
        e.b  = b;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    function automatic void push(int idx, exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void pop(int idx, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (idx)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endfunction

    function automatic int qsize(int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: pulse counting and scoreboard pops, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov_w[i]) ovr_cnt[i]++;
            if (bk_w[i]) brk_cnt[i]++;
            if (dv_w[i] && rdy[i]) begin
                pop(i, mon_e, mon_ok);
                if (!mon_ok) begin
                    chk("unexpected dv", i, 32'd1, 32'd0);
                end else begin
                    chk("byte", i, 32'(by_w[i]), 32'(mon_e.b));
                    chk("parity_err", i, 32'(pe_w[i]), 32'(mon_e.pe));
                    chk("frame_err", i, 32'(fe_w[i]), 32'(mon_e.fe));
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(int idx, logic v);
        ser[idx] = v;
        tick(Cpb);
    endtask

    // Line is left at the last stop-bit level.
    task automatic send(int idx, logic [7:0] d, int nd, int pbit, logic [1:0] stops, int nstop);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(idx, d[i]);
        if (pbit >= 0) drive_bit(idx, pbit[0]);
        for (int s = 0; s < nstop; s++) drive_bit(idx, stops[s]);
    endtask

    task automatic wait_dv(int idx, int budget);
        int n = 0;
        while (!dv_w[idx] && n < budget) begin
            tick(1);
            n++;
        end
        chk("dv arrives", idx, 32'(dv_w[idx]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hold_bad;
        int b0;
        int o0;

        rst = 1'b1;
        ser = 3'b111;
        rdy = 3'b111;
        @(posedge clk);
        #1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk("reset dv", i, 32'(dv_w[i]), 32'd0);
            chk("reset byte", i, 32'(by_w[i]), 32'd0);
            chk("reset flags", i, 32'({pe_w[i], fe_w[i], ov_w[i], bk_w[i]}), 32'd0);
        end
        rst = 1'b0;
        tick(5);

        // 8N1 0xA5 held for 40 clocks with ready low
        rdy[0] = 1'b0;
        push(0, mk(8'hA5, 1'b0, 1'b0));
        send(0, 8'hA5, 8, -1, 2'b11, 1);
        wait_dv(0, 60);
        hold_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!(dv_w[0] && by_w[0] == 8'hA5 && !pe_w[0] && !fe_w[0])) hold_bad++;
        end
        chk("held byte unstable", 0, 32'(hold_bad), 32'd0);
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        tick(1);
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("dv clears after accept", 0, 32'(dv_w[0]), 32'd0);
        @(posedge clk);
        #1;

        // 7E1: 0x41 has two ones, so parity bit 1 is an even-parity error
        push(1, mk(8'h41, 1'b1, 1'b0));
        send(1, 8'h41, 7, 1, 2'b11, 1);
        tick(2 * Cpb);
        push(1, mk(8'h41, 1'b0, 1'b0));
        send(1, 8'h41, 7, 0, 2'b11, 1);
        tick(2 * Cpb);

        // 8N2 with second stop low, then line stuck low for 100 clocks
        push(2, mk(8'h5A, 1'b0, 1'b1));
        send(2, 8'h5A, 8, -1, 2'b01, 2);
        tick(100);
        ser[2] = 1'b1;
        tick(2 * Cpb);
        push(2, mk(8'hC3, 1'b0, 1'b0));
        send(2, 8'hC3, 8, -1, 2'b11, 2);
        tick(2 * Cpb);

        // Break, then a short glitch, then a normal frame
        rdy[0] = 1'b1;
        b0 = brk_cnt[0];
        ser[0] = 1'b0;
        tick(200);
        ser[0] = 1'b1;
        tick(3 * Cpb);
        chk("break pulses", 0, 32'(brk_cnt[0] - b0), 32'd1);
        ser[0] = 1'b0;
        tick(4);
        ser[0] = 1'b1;
        tick(40);
        chk("dv after glitch", 0, 32'(dv_w[0]), 32'd0);
        push(0, mk(8'h3C, 1'b0, 1'b0));
        send(0, 8'h3C, 8, -1, 2'b11, 1);
        tick(2 * Cpb);

        // Overrun: 0x11 held, 0x22 dropped
        rdy[0] = 1'b0;
        o0 = ovr_cnt[0];
        push(0, mk(8'h11, 1'b0, 1'b0));
        send(0, 8'h11, 8, -1, 2'b11, 1);
        send(0, 8'h22, 8, -1, 2'b11, 1);
        tick(Cpb);
        chk("overrun pulses", 0, 32'(ovr_cnt[0] - o0), 32'd1);
        chk("dv held over overrun", 0, 32'(dv_w[0]), 32'd1);
        chk("byte held over overrun", 0, 32'(by_w[0]), 32'h11);
        rdy[0] = 1'b1;
        tick(4);
        chk("dv after drain", 0, 32'(dv_w[0]), 32'd0);

        // Reset mid-frame, then a clean frame
        b0 = brk_cnt[0];
        o0 = ovr_cnt[0];
        ser[0] = 1'b0;
        tick(3 * Cpb);
        rst = 1'b1;
        ser[0] = 1'b1;
        tick(1);
        chk("dv in reset", 0, 32'(dv_w[0]), 32'd0);
        chk("byte in reset", 0, 32'(by_w[0]), 32'd0);
        chk("flags in reset", 0, 32'({pe_w[0], fe_w[0], ov_w[0], bk_w[0]}), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3 * Cpb);
        chk("no pulses after reset", 0, 32'((brk_cnt[0] - b0) + (ovr_cnt[0] - o0)), 32'd0);
        chk("no dv after reset", 0, 32'(dv_w[0]), 32'd0);
        push(0, mk(8'h33, 1'b0, 1'b0));
        send(0, 8'h33, 8, -1, 2'b11, 1);
        tick(2 * Cpb);

        tick(20);
        for (int i = 0; i < 3; i++) chk("frames outstanding", i, 32'(qsize(i)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
